// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Types and constants shared by the fetch unit and its skid register.
//   fetch_state_t    : FETCH = normal fetching, DROP = discard one stale response
//   INSTR_NOP        : addi x0,x0,0, presented to decode whenever the slot is empty
//   RESET_PC_DEFAULT : default first fetch address after reset
// ----------------------------------------------------------------------------
package riscv_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // True when an address is not on a 32-bit word boundary.
   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return (low_bits != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// ----------------------------------------------------------------------------
// fetch_skid_reg
//   One-entry {instr, pc} holding register. Catches a fetched word that
//   arrives while decode is stalled so the memory handshake never has to
//   be extended once it completes.
//   Ports:
//     clk       rising-edge clock
//     resetN    synchronous reset, active-low
//     flush_i   drop any held entry (highest priority)
//     load_i    capture instr_i/pc_i (wins over unload_i)
//     unload_i  entry consumed, becomes empty
//     instr_i   instruction word to capture
//     pc_i      address of instr_i
//     valid_o   entry holds a word
//     instr_o   held instruction
//     pc_o      held address
// ----------------------------------------------------------------------------
module fetch_skid_reg
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            resetN,
   input  logic            flush_i,
   input  logic            load_i,
   input  logic            unload_i,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o
);

   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;

   // Next-entry selection: flush beats load, load beats unload.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         instr_d = instr_i;
         pc_d    = pc_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry storage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         valid_q <= 1'b0;
         instr_q <= INSTR_NOP;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: owns the fetch PC, requests words over a req/ack handshake
//   and presents one registered {instr, pc} slot to decode. A one-entry skid
//   register absorbs a word that lands while decode is stalled. After a
//   redirect with a request still in flight the unit enters DROP and throws
//   away that one stale response.
//   Ports:
//     clk, resetN   clock, synchronous active-low reset
//     stall         decode cannot accept; slot is held
//     pcSrc         redirect strobe, taken only when instrValid && !stall
//     pcTarget      redirect address (low two bits forced to zero)
//     imemReq/Addr  fetch request and word-aligned address
//     imemAck/Rdata response valid and instruction word
//     instrValid    slot holds a live instruction
//     instr, pc     slot contents (instr = NOP when not valid)
//     pcPlus4       pc + 4, wrapping
//     misalignErr   sticky: a redirect target had nonzero low bits
// ----------------------------------------------------------------------------
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            resetN,
   input  logic            stall,
   input  logic            pcSrc,
   input  logic [XLEN-1:0] pcTarget,
   output logic            imemReq,
   output logic [XLEN-1:0] imemAddr,
   input  logic            imemAck,
   input  logic [31:0]     imemRdata,
   output logic            instrValid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pcPlus4,
   output logic            misalignErr
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetchPc_q, fetchPc_d;
   logic [XLEN-1:0] dropAddr_q, dropAddr_d;
   logic            reqPending_q, reqPending_d;
   logic            instrValid_q, instrValid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            misalignErr_q, misalignErr_d;

   logic            skidValid_s;
   logic [31:0]     skidInstr_s;
   logic [XLEN-1:0] skidPc_s;
   logic            skidLoad_s, skidUnload_s, skidFlush_s;

   logic            imemReq_s;
   logic            accept_s;
   logic            slotFree_s;
   logic            redirect_s;

   // A new request only starts with the skid empty, so one buffered word
   // is enough to ride out an indefinite stall.
   assign imemReq_s  = resetN & (reqPending_q | (state_q == DROP) |
                                 ((state_q == FETCH) & ~skidValid_s));
   assign accept_s   = imemReq_s & imemAck;
   assign slotFree_s = ~instrValid_q | ~stall;
   assign redirect_s = pcSrc & instrValid_q & ~stall;

   fetch_skid_reg #(.XLEN(XLEN)) u_skid (
      .clk      (clk),
      .resetN   (resetN),
      .flush_i  (skidFlush_s),
      .load_i   (skidLoad_s),
      .unload_i (skidUnload_s),
      .instr_i  (imemRdata),
      .pc_i     (fetchPc_q),
      .valid_o  (skidValid_s),
      .instr_o  (skidInstr_s),
      .pc_o     (skidPc_s)
   );

   // Next-state logic for the FSM, fetch PC, output slot and skid control.
   always_comb begin
      state_d       = state_q;
      fetchPc_d     = fetchPc_q;
      dropAddr_d    = dropAddr_q;
      reqPending_d  = imemReq_s & ~imemAck;
      instrValid_d  = instrValid_q;
      instr_d       = instr_q;
      pc_d          = pc_q;
      misalignErr_d = misalignErr_q;
      skidLoad_s    = 1'b0;
      skidUnload_s  = 1'b0;
      skidFlush_s   = 1'b0;
      case (state_q)
         FETCH: begin
            if (redirect_s) begin
               instrValid_d  = 1'b0;
               instr_d       = INSTR_NOP;
               skidFlush_s   = 1'b1;
               fetchPc_d     = {pcTarget[XLEN-1:2], 2'b00};
               misalignErr_d = misalignErr_q | is_misaligned(pcTarget[1:0]);
               // An unanswered request must stay on the bus; its data is stale.
               if (imemReq_s && !imemAck) begin
                  state_d    = DROP;
                  dropAddr_d = fetchPc_q;
               end else begin
                  state_d    = FETCH;
               end
            end else if (accept_s) begin
               fetchPc_d = fetchPc_q + PC_STEP;
               if (slotFree_s) begin
                  instrValid_d = 1'b1;
                  if (skidValid_s) begin
                     // Older skid word goes first; new word refills the skid.
                     instr_d    = skidInstr_s;
                     pc_d       = skidPc_s;
                     skidLoad_s = 1'b1;
                  end else begin
                     instr_d    = imemRdata;
                     pc_d       = fetchPc_q;
                  end
               end else begin
                  skidLoad_s = 1'b1;
               end
            end else if (slotFree_s) begin
               if (skidValid_s) begin
                  instrValid_d = 1'b1;
                  instr_d      = skidInstr_s;
                  pc_d         = skidPc_s;
                  skidUnload_s = 1'b1;
               end else begin
                  instrValid_d = 1'b0;
                  instr_d      = INSTR_NOP;
               end
            end else begin
               instrValid_d = instrValid_q;
            end
         end
         DROP: begin
            // Slot is already empty here; only wait for the stale response.
            if (accept_s) begin
               state_d = FETCH;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q       <= FETCH;
         fetchPc_q     <= RESET_PC;
         dropAddr_q    <= RESET_PC;
         reqPending_q  <= 1'b0;
         instrValid_q  <= 1'b0;
         instr_q       <= INSTR_NOP;
         pc_q          <= RESET_PC;
         misalignErr_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetchPc_q     <= fetchPc_d;
         dropAddr_q    <= dropAddr_d;
         reqPending_q  <= reqPending_d;
         instrValid_q  <= instrValid_d;
         instr_q       <= instr_d;
         pc_q          <= pc_d;
         misalignErr_q <= misalignErr_d;
      end
   end

   assign imemReq     = imemReq_s;
   assign imemAddr    = (state_q == DROP) ? dropAddr_q : fetchPc_q;
   assign instrValid  = instrValid_q;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign pcPlus4     = pc_q + PC_STEP;
   assign misalignErr = misalignErr_q;

endmodule
